map_table_nway: RTL and testbench
=================================

Name: map_table_nway

Overview:
- N-wide successor to the single-issue rename map table, sitting between decode/dispatch and the RS/ROB.
- Holds a speculative map (arch reg -> PREG with ready bit) and a retired architectural map.
- Per cycle it serves DISPATCH_W rename groups with intra-group dependency bypass, CDB_W ready broadcasts and RETIRE_W retirements.
- Restore runs as a two-cycle recovery sequence with a stall output.

Parameters:
- ARCH_REGS, 32, architectural registers; index 0 is the hardwired zero reg.
- PHYS_REGS, 64, physical registers; must be >= ARCH_REGS.
- DISPATCH_W, 2, rename slots per cycle; slot 0 is oldest.
- CDB_W, 2, ready-broadcast ports.
- RETIRE_W, 2, retire ports; port 0 is oldest.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- src1_arch_idx  in  DISPATCH_W x $clog2(ARCH_REGS)  opA arch index per slot.
- src2_arch_idx  in  DISPATCH_W x $clog2(ARCH_REGS)  opB arch index per slot.
- src1_preg  out  DISPATCH_W x PREG  renamed opA (reg_num, ready).
- src2_preg  out  DISPATCH_W x PREG  renamed opB.
- dest_arch_idx  in  DISPATCH_W x $clog2(ARCH_REGS)  dest arch index per slot.
- dest_valid  in  DISPATCH_W  slot writes a new mapping.
- dest_new_preg  in  DISPATCH_W x $clog2(PHYS_REGS)  freelist-allocated preg.
- dest_old_preg  out  DISPATCH_W x PREG  prior mapping, for the ROB to free.
- cdb_valid  in  CDB_W  broadcast valid.
- cdb_preg  in  CDB_W x $clog2(PHYS_REGS)  completed preg.
- retire_valid  in  RETIRE_W  retire valid.
- retire_arch_idx  in  RETIRE_W x $clog2(ARCH_REGS)  retiring arch dest.
- retire_preg  in  RETIRE_W x $clog2(PHYS_REGS)  retiring preg.
- restore_enable  in  1  mispredict/exception recovery request.
- busy  out  1  recovery in progress; dispatch must stall.
- arch_map_out  out  ARCH_REGS x $clog2(PHYS_REGS)  retired map, registered; used by the register-file dump.

Behaviour:
- Reset (asynchronous):
  - Spec entry i = {reg_num=i, ready=1}; arch entry i = i.
  - FSM returns to RUN; busy=0.
  - Reset mid-recovery aborts recovery immediately.
- Zero reg:
  - Any read of arch idx 0 returns {0, ready=1}.
  - Writes and retires targeting idx 0 are ignored.
- Reads are combinational from the current spec map and take effect in the same cycle.
  - Intra-group bypass: slot k's src or old-dest read takes the value written by the youngest slot j<k with dest_valid and a matching dest_arch_idx. That value is {dest_new_preg[j], ready=0}, and it takes precedence over the table and the CDB.
  - CDB bypass: a table-sourced read returns ready=1 if any cdb_valid port matches its reg_num.
- Writes on posedge, in RUN only:
  - Each valid dest slot writes {new_preg, 0}.
  - Same arch idx in several slots: the youngest slot wins.
  - CDB ports set ready=1 on every entry whose reg_num matches.
  - A same-cycle dest write overrides the CDB for that entry.
- Retire on posedge, all states:
  - arch[idx] <= preg for each valid port.
  - Duplicate idx: the highest-numbered port wins.
- FSM RUN -> RECOVER:
  - Triggered by restore_enable in RUN.
  - At that edge, dest writes are dropped.
  - Spec map <= arch map after applying same-cycle retirements, all ready=1.
  - busy=1 for the whole RECOVER cycle.
- FSM RECOVER -> RUN:
  - Unconditional after one cycle.
  - dest_valid, CDB and restore_enable are ignored in RECOVER.
  - Retire ports are still honoured in RECOVER, updating both maps.
- Boundaries:
  - Same preg on two CDB ports: idempotent.
  - CDB for a preg that no arch reg maps to: no effect.
  - restore_enable held asserted: one recovery per RUN entry.

Optional Feature:
- Macro MAP_TABLE_CHECKPOINT_EN.
- Defined:
  - Adds NUM_CKPT (default 4) snapshots of the spec map.
  - Adds ports ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id.
  - Save captures the post-dispatch map on the edge; the snapshot includes that cycle's dest writes.
  - Subsequent CDB broadcasts also set ready in every valid snapshot.
  - ckpt_restore copies the snapshot in one edge, without entering RECOVER.
  - restore_enable has priority over ckpt_restore.
- Undefined: ports absent; recovery only via arch map.

Decomposition:
- Shared package sys_defs:
  - PREG typedef {reg_num, ready}.
  - ZERO_REG constant.
  - mt_state_e enum {MT_RUN, MT_RECOVER}.
  - Width localparams derived with $clog2.
- Sub-module mt_group_bypass: combinational priority search across DISPATCH_W slots, instantiated once per read port class (src1, src2, old dest).

Test Plan:
- Reset then read slot0 src1=5 -> {5, ready=1}; arch_map_out[5]=5; busy=0.
- Slot0 dest r3<-p40 and slot1 src1=r3, dest r3<-p41 in the same cycle:
  - slot1 src1={40,0}; slot1 old_dest={40,0}.
  - Next cycle read r3={41,0}.
- Map r7->p50, then CDB p50 on port1 alongside a read of r7 in the same cycle:
  - Read ready=1 in that cycle.
  - Table shows ready=1 the cycle after.
- Retire r7/p50, dispatch r7<-p55, then restore_enable:
  - busy=1 for one cycle; dispatch ignored in that cycle.
  - After recovery, r7={50,1}.
- Retire r2/p60 in the same cycle as restore_enable -> after recovery, r2={60,1} (retirement folded into restore).
- Assert reset while busy=1 -> busy=0 at once; r7={7,1}.

Source files
------------

// File: rtl/map_table_nway_pkg.sv
// Shared definitions for the N-wide rename map table: physical-register
// entry type, zero-register index, recovery FSM states and default sizes.
// Optional checkpoint support is enabled with MAP_TABLE_CHECKPOINT_EN.
package sys_defs;

  localparam int unsigned MT_ARCH_REGS  = 32;
  localparam int unsigned MT_PHYS_REGS  = 64;
  localparam int unsigned MT_DISPATCH_W = 2;
  localparam int unsigned MT_CDB_W      = 2;
  localparam int unsigned MT_RETIRE_W   = 2;
  localparam int unsigned MT_NUM_CKPT   = 4;

  localparam int unsigned MT_ARCH_IDX_W = $clog2(MT_ARCH_REGS);
  localparam int unsigned MT_PREG_W     = $clog2(MT_PHYS_REGS);

  // Map-table entry: physical register number plus value-ready flag.
  typedef struct packed {
    logic [MT_PREG_W-1:0] reg_num;
    logic                 ready;
  } PREG;

  localparam logic [MT_ARCH_IDX_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    MT_RUN     = 1'b0,
    MT_RECOVER = 1'b1
  } mt_state_e;

endpackage

// File: rtl/map_table_nway_if.sv
// Dispatch / CDB / retire / recovery bundle for map_table_nway.
// Checkpoint controls exist only with MAP_TABLE_CHECKPOINT_EN.
interface map_table_nway_if
  import sys_defs::*;
#(
  parameter int unsigned ARCH_REGS  = MT_ARCH_REGS,
  parameter int unsigned PHYS_REGS  = MT_PHYS_REGS,
  parameter int unsigned DISPATCH_W = MT_DISPATCH_W,
  parameter int unsigned CDB_W      = MT_CDB_W,
  parameter int unsigned RETIRE_W   = MT_RETIRE_W
`ifdef MAP_TABLE_CHECKPOINT_EN
  , parameter int unsigned NUM_CKPT = MT_NUM_CKPT
`endif
);
  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned PW = $clog2(PHYS_REGS);

  logic [DISPATCH_W-1:0][AW-1:0] src1_arch_idx;
  logic [DISPATCH_W-1:0][AW-1:0] src2_arch_idx;
  PREG  [DISPATCH_W-1:0]         src1_preg;
  PREG  [DISPATCH_W-1:0]         src2_preg;
  logic [DISPATCH_W-1:0][AW-1:0] dest_arch_idx;
  logic [DISPATCH_W-1:0]         dest_valid;
  logic [DISPATCH_W-1:0][PW-1:0] dest_new_preg;
  PREG  [DISPATCH_W-1:0]         dest_old_preg;
  logic [CDB_W-1:0]              cdb_valid;
  logic [CDB_W-1:0][PW-1:0]      cdb_preg;
  logic [RETIRE_W-1:0]           retire_valid;
  logic [RETIRE_W-1:0][AW-1:0]   retire_arch_idx;
  logic [RETIRE_W-1:0][PW-1:0]   retire_preg;
  logic                          restore_enable;
  logic                          busy;
  logic [ARCH_REGS-1:0][PW-1:0]  arch_map_out;
`ifdef MAP_TABLE_CHECKPOINT_EN
  logic                          ckpt_save;
  logic [$clog2(NUM_CKPT)-1:0]   ckpt_save_id;
  logic                          ckpt_restore;
  logic [$clog2(NUM_CKPT)-1:0]   ckpt_restore_id;
`endif

  modport master (
    output src1_arch_idx, src2_arch_idx, dest_arch_idx, dest_valid, dest_new_preg,
           cdb_valid, cdb_preg, retire_valid, retire_arch_idx, retire_preg,
           restore_enable
`ifdef MAP_TABLE_CHECKPOINT_EN
    , output ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id
`endif
    , input src1_preg, src2_preg, dest_old_preg, busy, arch_map_out
  );

  modport slave (
    input  src1_arch_idx, src2_arch_idx, dest_arch_idx, dest_valid, dest_new_preg,
           cdb_valid, cdb_preg, retire_valid, retire_arch_idx, retire_preg,
           restore_enable
`ifdef MAP_TABLE_CHECKPOINT_EN
    , input ckpt_save, ckpt_save_id, ckpt_restore, ckpt_restore_id
`endif
    , output src1_preg, src2_preg, dest_old_preg, busy, arch_map_out
  );

endinterface

// File: rtl/map_table_nway_bypass.sv
// mt_group_bypass: per-slot read with intra-group forwarding. Slot k sees
// the youngest older slot's new mapping for the same arch reg, otherwise
// the (CDB-forwarded) table value; arch reg 0 always reads {0, ready}.
module mt_group_bypass
  import sys_defs::*;
#(
  parameter int unsigned DISPATCH_W = MT_DISPATCH_W,
  parameter int unsigned AW         = MT_ARCH_IDX_W,
  parameter int unsigned PW         = MT_PREG_W
) (
  input  logic [DISPATCH_W-1:0][AW-1:0] rd_idx_i,
  input  PREG  [DISPATCH_W-1:0]         tbl_i,
  input  logic [DISPATCH_W-1:0][AW-1:0] dest_idx_i,
  input  logic [DISPATCH_W-1:0]         dest_valid_i,
  input  logic [DISPATCH_W-1:0][PW-1:0] dest_new_i,
  output PREG  [DISPATCH_W-1:0]         rd_o
);

  // Priority search: later (younger) matching slots overwrite earlier ones.
  always_comb begin
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      rd_o[k] = tbl_i[k];
      for (int unsigned j = 0; j < k; j++) begin
        if (dest_valid_i[j] && dest_idx_i[j] != ZERO_REG && dest_idx_i[j] == rd_idx_i[k])
          rd_o[k] = '{reg_num: dest_new_i[j], ready: 1'b0};
      end
      if (rd_idx_i[k] == ZERO_REG)
        rd_o[k] = '{reg_num: '0, ready: 1'b1};
    end
  end

endmodule

// File: rtl/map_table_nway.sv
// map_table_nway: N-wide rename map table with speculative and retired
// maps, CDB ready broadcast, retirement and two-cycle restore (busy).
// MAP_TABLE_CHECKPOINT_EN adds NUM_CKPT speculative-map snapshots.
module map_table_nway
  import sys_defs::*;
#(
  parameter int unsigned ARCH_REGS  = MT_ARCH_REGS,
  parameter int unsigned PHYS_REGS  = MT_PHYS_REGS,
  parameter int unsigned DISPATCH_W = MT_DISPATCH_W,
  parameter int unsigned CDB_W      = MT_CDB_W,
  parameter int unsigned RETIRE_W   = MT_RETIRE_W
`ifdef MAP_TABLE_CHECKPOINT_EN
  , parameter int unsigned NUM_CKPT = MT_NUM_CKPT
`endif
) (
  input logic            clk,
  input logic            reset,
  map_table_nway_if.slave mt
);
  localparam int unsigned AW = $clog2(ARCH_REGS);
  localparam int unsigned PW = $clog2(PHYS_REGS);

  PREG        spec_q [ARCH_REGS];
  PREG        spec_d [ARCH_REGS];
  logic [PW-1:0] arch_q [ARCH_REGS];
  logic [PW-1:0] arch_d [ARCH_REGS];
  mt_state_e  state_q, state_d;
`ifdef MAP_TABLE_CHECKPOINT_EN
  PREG                 ckpt_q [NUM_CKPT][ARCH_REGS];
  PREG                 ckpt_d [NUM_CKPT][ARCH_REGS];
  logic [NUM_CKPT-1:0] ckpt_vld_q, ckpt_vld_d;
`endif

  logic                          run;
  logic [CDB_W-1:0]              cdb_v;
  logic [DISPATCH_W-1:0]         dest_v;
  PREG  [DISPATCH_W-1:0]         tbl_s1, tbl_s2, tbl_od;
  logic [ARCH_REGS-1:0][PW-1:0]  arch_flat;

  // Dispatch and CDB have no effect while recovering.
  assign run    = (state_q == MT_RUN);
  assign cdb_v  = run ? mt.cdb_valid  : '0;
  assign dest_v = run ? mt.dest_valid : '0;
  assign mt.busy = ~run;

  function automatic PREG cdb_fwd(input PREG e, input logic [CDB_W-1:0] v,
                                  input logic [CDB_W-1:0][PW-1:0] p);
    PREG r;
    r = e;
    for (int unsigned c = 0; c < CDB_W; c++)
      if (v[c] && p[c] == e.reg_num) r.ready = 1'b1;
    return r;
  endfunction

  // Table reads with same-cycle CDB readiness.
  always_comb begin
    for (int unsigned k = 0; k < DISPATCH_W; k++) begin
      tbl_s1[k] = cdb_fwd(spec_q[mt.src1_arch_idx[k]], cdb_v, mt.cdb_preg);
      tbl_s2[k] = cdb_fwd(spec_q[mt.src2_arch_idx[k]], cdb_v, mt.cdb_preg);
      tbl_od[k] = cdb_fwd(spec_q[mt.dest_arch_idx[k]], cdb_v, mt.cdb_preg);
    end
  end

  mt_group_bypass #(.DISPATCH_W(DISPATCH_W), .AW(AW), .PW(PW)) u_byp_src1 (
    .rd_idx_i(mt.src1_arch_idx), .tbl_i(tbl_s1), .dest_idx_i(mt.dest_arch_idx),
    .dest_valid_i(dest_v), .dest_new_i(mt.dest_new_preg), .rd_o(mt.src1_preg));

  mt_group_bypass #(.DISPATCH_W(DISPATCH_W), .AW(AW), .PW(PW)) u_byp_src2 (
    .rd_idx_i(mt.src2_arch_idx), .tbl_i(tbl_s2), .dest_idx_i(mt.dest_arch_idx),
    .dest_valid_i(dest_v), .dest_new_i(mt.dest_new_preg), .rd_o(mt.src2_preg));

  mt_group_bypass #(.DISPATCH_W(DISPATCH_W), .AW(AW), .PW(PW)) u_byp_old (
    .rd_idx_i(mt.dest_arch_idx), .tbl_i(tbl_od), .dest_idx_i(mt.dest_arch_idx),
    .dest_valid_i(dest_v), .dest_new_i(mt.dest_new_preg), .rd_o(mt.dest_old_preg));

  // Next-state for both maps and the recovery FSM.
  always_comb begin
    arch_d = arch_q;
    for (int unsigned r = 0; r < RETIRE_W; r++)
      if (mt.retire_valid[r] && mt.retire_arch_idx[r] != ZERO_REG)
        arch_d[mt.retire_arch_idx[r]] = mt.retire_preg[r];

    spec_d  = spec_q;
    state_d = state_q;
`ifdef MAP_TABLE_CHECKPOINT_EN
    ckpt_d     = ckpt_q;
    ckpt_vld_d = ckpt_vld_q;
    for (int unsigned c = 0; c < NUM_CKPT; c++)
      if (ckpt_vld_q[c])
        for (int unsigned i = 0; i < ARCH_REGS; i++)
          ckpt_d[c][i] = cdb_fwd(ckpt_q[c][i], cdb_v, mt.cdb_preg);
`endif

    if (run) begin
      if (mt.restore_enable) begin
        // Restore from the retired map including this edge's retirements.
        for (int unsigned i = 0; i < ARCH_REGS; i++)
          spec_d[i] = '{reg_num: arch_d[i], ready: 1'b1};
        state_d = MT_RECOVER;
      end
`ifdef MAP_TABLE_CHECKPOINT_EN
      else if (mt.ckpt_restore) begin
        spec_d = ckpt_d[mt.ckpt_restore_id];
      end
`endif
      else begin
        for (int unsigned i = 0; i < ARCH_REGS; i++)
          spec_d[i] = cdb_fwd(spec_q[i], cdb_v, mt.cdb_preg);
        // Ascending slot order lets the youngest slot win, and dest writes
        // override the CDB ready set above.
        for (int unsigned k = 0; k < DISPATCH_W; k++)
          if (dest_v[k] && mt.dest_arch_idx[k] != ZERO_REG)
            spec_d[mt.dest_arch_idx[k]] = '{reg_num: mt.dest_new_preg[k], ready: 1'b0};
      end
`ifdef MAP_TABLE_CHECKPOINT_EN
      if (!mt.restore_enable && mt.ckpt_save) begin
        ckpt_d[mt.ckpt_save_id]     = spec_d;
        ckpt_vld_d[mt.ckpt_save_id] = 1'b1;
      end
`endif
    end else begin
      // Retirements during recovery land in the freshly restored map too.
      for (int unsigned r = 0; r < RETIRE_W; r++)
        if (mt.retire_valid[r] && mt.retire_arch_idx[r] != ZERO_REG)
          spec_d[mt.retire_arch_idx[r]] = '{reg_num: mt.retire_preg[r], ready: 1'b1};
      state_d = MT_RUN;
    end
  end

  // Map and FSM registers; reset gives the identity mapping, all ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MT_RUN;
      for (int unsigned i = 0; i < ARCH_REGS; i++) begin
        spec_q[i] <= '{reg_num: PW'(i), ready: 1'b1};
        arch_q[i] <= PW'(i);
      end
    end else begin
      state_q <= state_d;
      spec_q  <= spec_d;
      arch_q  <= arch_d;
    end
  end

`ifdef MAP_TABLE_CHECKPOINT_EN
  // Snapshot storage; all snapshots are invalid after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ckpt_vld_q <= '0;
      for (int unsigned c = 0; c < NUM_CKPT; c++)
        for (int unsigned i = 0; i < ARCH_REGS; i++)
          ckpt_q[c][i] <= '0;
    end else begin
      ckpt_vld_q <= ckpt_vld_d;
      ckpt_q     <= ckpt_d;
    end
  end
`endif

  // Registered retired map for the register-file dump.
  always_comb begin
    for (int unsigned i = 0; i < ARCH_REGS; i++)
      arch_flat[i] = arch_q[i];
  end
  assign mt.arch_map_out = arch_flat;

endmodule

// File: tb/tb_map_table_nway.sv
// Self-checking bench for map_table_nway: directed scenarios followed by
// randomized traffic, checked against an array-based reference model.
module tb_map_table_nway;
  import sys_defs::*;

  localparam int unsigned AR = 32;
  localparam int unsigned PR = 64;
  localparam int unsigned DW = 2;
  localparam int unsigned CW = 2;
  localparam int unsigned RW = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  map_table_nway_if #(.ARCH_REGS(AR), .PHYS_REGS(PR), .DISPATCH_W(DW),
                      .CDB_W(CW), .RETIRE_W(RW)) mt ();

  map_table_nway #(.ARCH_REGS(AR), .PHYS_REGS(PR), .DISPATCH_W(DW),
                   .CDB_W(CW), .RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .mt(mt));

  // Reference model state.
  logic [5:0] m_num  [AR];
  bit         m_rdy  [AR];
  logic [5:0] m_arch [AR];
  bit         m_busy;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ev(input logic [5:0] n, input bit r);
    return {25'b0, n, r};
  endfunction

  function automatic logic [31:0] pv(input PREG p);
    return {25'b0, p};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < AR; i++) begin
      m_num[i]  = 6'(i);
      m_rdy[i]  = 1'b1;
      m_arch[i] = 6'(i);
    end
    m_busy = 1'b0;
  endtask

  // Rename read as seen by slot `slot`: zero reg, older-slot forwarding,
  // then table value with same-cycle CDB readiness.
  function automatic logic [31:0] exp_read(input int slot, input logic [4:0] idx);
    bit r;
    if (idx == 5'd0) return ev(6'd0, 1'b1);
    for (int j = slot - 1; j >= 0; j--)
      if (mt.dest_valid[j] && mt.dest_arch_idx[j] == idx)
        return ev(mt.dest_new_preg[j], 1'b0);
    r = m_rdy[idx];
    for (int c = 0; c < CW; c++)
      if (mt.cdb_valid[c] && mt.cdb_preg[c] == m_num[idx]) r = 1'b1;
    return ev(m_num[idx], r);
  endfunction

  task automatic clr();
    mt.src1_arch_idx   = '0;
    mt.src2_arch_idx   = '0;
    mt.dest_arch_idx   = '0;
    mt.dest_valid      = '0;
    mt.dest_new_preg   = '0;
    mt.cdb_valid       = '0;
    mt.cdb_preg        = '0;
    mt.retire_valid    = '0;
    mt.retire_arch_idx = '0;
    mt.retire_preg     = '0;
    mt.restore_enable  = 1'b0;
`ifdef MAP_TABLE_CHECKPOINT_EN
    mt.ckpt_save       = 1'b0;
    mt.ckpt_save_id    = '0;
    mt.ckpt_restore    = 1'b0;
    mt.ckpt_restore_id = '0;
`endif
  endtask

  // Mid-low-phase combinational checks (only meaningful outside recovery).
  task automatic settle();
    #1;
    if (!m_busy) begin
      for (int k = 0; k < DW; k++) begin
        chk($sformatf("src1[%0d]", k), pv(mt.src1_preg[k]),     exp_read(k, mt.src1_arch_idx[k]));
        chk($sformatf("src2[%0d]", k), pv(mt.src2_preg[k]),     exp_read(k, mt.src2_arch_idx[k]));
        chk($sformatf("old[%0d]", k),  pv(mt.dest_old_preg[k]), exp_read(k, mt.dest_arch_idx[k]));
      end
    end
  endtask

  // Apply the clock-edge rules to the model, clock the DUT, check state.
  task automatic edge_step();
    logic [5:0] na [AR];
    na = m_arch;
    for (int r = 0; r < RW; r++)
      if (mt.retire_valid[r] && mt.retire_arch_idx[r] != 5'd0)
        na[mt.retire_arch_idx[r]] = mt.retire_preg[r];
    if (!m_busy) begin
      if (mt.restore_enable) begin
        for (int i = 0; i < AR; i++) begin
          m_num[i] = na[i];
          m_rdy[i] = 1'b1;
        end
        m_busy = 1'b1;
      end else begin
        for (int i = 0; i < AR; i++)
          for (int c = 0; c < CW; c++)
            if (mt.cdb_valid[c] && mt.cdb_preg[c] == m_num[i]) m_rdy[i] = 1'b1;
        for (int k = 0; k < DW; k++)
          if (mt.dest_valid[k] && mt.dest_arch_idx[k] != 5'd0) begin
            m_num[mt.dest_arch_idx[k]] = mt.dest_new_preg[k];
            m_rdy[mt.dest_arch_idx[k]] = 1'b0;
          end
      end
    end else begin
      for (int r = 0; r < RW; r++)
        if (mt.retire_valid[r] && mt.retire_arch_idx[r] != 5'd0) begin
          m_num[mt.retire_arch_idx[r]] = mt.retire_preg[r];
          m_rdy[mt.retire_arch_idx[r]] = 1'b1;
        end
      m_busy = 1'b0;
    end
    m_arch = na;
    @(posedge clk);
    #1;
    chk("busy", {31'b0, mt.busy}, {31'b0, m_busy});
    for (int i = 0; i < AR; i++)
      chk($sformatf("arch_map[%0d]", i), {26'b0, mt.arch_map_out[i]}, {26'b0, m_arch[i]});
    @(negedge clk);
  endtask

  initial begin
    clr();
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state.
    mt.src1_arch_idx[0] = 5'd5;
    settle();
    chk("rst_src1_r5", pv(mt.src1_preg[0]), ev(6'd5, 1'b1));
    chk("rst_arch5", {26'b0, mt.arch_map_out[5]}, 32'd5);
    chk("rst_busy", {31'b0, mt.busy}, 32'd0);
    edge_step();

    // Intra-group bypass on r3.
    clr();
    mt.dest_valid = 2'b11;
    mt.dest_arch_idx[0] = 5'd3; mt.dest_new_preg[0] = 6'd40;
    mt.dest_arch_idx[1] = 5'd3; mt.dest_new_preg[1] = 6'd41;
    mt.src1_arch_idx[1] = 5'd3;
    settle();
    chk("byp_src1_s1", pv(mt.src1_preg[1]),     ev(6'd40, 1'b0));
    chk("byp_old_s1",  pv(mt.dest_old_preg[1]), ev(6'd40, 1'b0));
    edge_step();
    clr();
    mt.src1_arch_idx[0] = 5'd3;
    settle();
    chk("r3_after", pv(mt.src1_preg[0]), ev(6'd41, 1'b0));
    edge_step();

    // CDB bypass on r7 -> p50.
    clr();
    mt.dest_valid[0] = 1'b1; mt.dest_arch_idx[0] = 5'd7; mt.dest_new_preg[0] = 6'd50;
    settle();
    edge_step();
    clr();
    mt.src1_arch_idx[0] = 5'd7;
    mt.cdb_valid[1] = 1'b1; mt.cdb_preg[1] = 6'd50;
    settle();
    chk("cdb_byp_r7", pv(mt.src1_preg[0]), ev(6'd50, 1'b1));
    edge_step();
    clr();
    mt.src1_arch_idx[0] = 5'd7;
    settle();
    chk("cdb_tbl_r7", pv(mt.src1_preg[0]), ev(6'd50, 1'b1));
    edge_step();

    // Duplicate CDB and CDB to an unmapped preg.
    clr();
    mt.cdb_valid = 2'b11; mt.cdb_preg[0] = 6'd63; mt.cdb_preg[1] = 6'd63;
    mt.src1_arch_idx[0] = 5'd3;
    settle();
    edge_step();

    // Retire r7/p50 while dispatching r7<-p55, then restore.
    clr();
    mt.retire_valid[0] = 1'b1; mt.retire_arch_idx[0] = 5'd7; mt.retire_preg[0] = 6'd50;
    mt.dest_valid[0] = 1'b1; mt.dest_arch_idx[0] = 5'd7; mt.dest_new_preg[0] = 6'd55;
    settle();
    edge_step();
    clr();
    mt.restore_enable = 1'b1;
    mt.dest_valid[1] = 1'b1; mt.dest_arch_idx[1] = 5'd7; mt.dest_new_preg[1] = 6'd57;
    settle();
    edge_step();
    chk("busy_recover", {31'b0, mt.busy}, 32'd1);
    clr();
    mt.dest_valid[0] = 1'b1; mt.dest_arch_idx[0] = 5'd7; mt.dest_new_preg[0] = 6'd56;
    settle();
    edge_step();
    chk("busy_done", {31'b0, mt.busy}, 32'd0);
    clr();
    mt.src1_arch_idx[0] = 5'd7;
    settle();
    chk("r7_restored", pv(mt.src1_preg[0]), ev(6'd50, 1'b1));
    edge_step();

    // Retirement folded into the restore edge.
    clr();
    mt.restore_enable = 1'b1;
    mt.retire_valid[1] = 1'b1; mt.retire_arch_idx[1] = 5'd2; mt.retire_preg[1] = 6'd60;
    settle();
    edge_step();
    clr();
    settle();
    edge_step();
    mt.src2_arch_idx[1] = 5'd2;
    settle();
    chk("r2_folded", pv(mt.src2_preg[1]), ev(6'd60, 1'b1));
    edge_step();

    // restore_enable held: recovery on every RUN entry.
    clr();
    mt.restore_enable = 1'b1;
    for (int n = 0; n < 4; n++) begin
      settle();
      edge_step();
      chk("held_busy", {31'b0, mt.busy}, {31'b0, (n % 2 == 0)});
    end

    // Reset mid-recovery.
    clr();
    mt.restore_enable = 1'b1;
    settle();
    edge_step();
    clr();
    mt.src1_arch_idx[0] = 5'd7;
    reset = 1'b1;
    model_reset();
    #1;
    chk("rst_busy_abort", {31'b0, mt.busy}, 32'd0);
    chk("rst_r7", pv(mt.src1_preg[0]), ev(6'd7, 1'b1));
    reset = 1'b0;
    @(negedge clk);

    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      clr();
      for (int k = 0; k < DW; k++) begin
        mt.src1_arch_idx[k] = 5'($urandom_range(0, 7));
        mt.src2_arch_idx[k] = 5'($urandom_range(0, 7));
        mt.dest_arch_idx[k] = 5'($urandom_range(0, 7));
        mt.dest_valid[k]    = 1'($urandom_range(0, 1));
        mt.dest_new_preg[k] = 6'($urandom_range(0, 63));
      end
      for (int c = 0; c < CW; c++) begin
        mt.cdb_valid[c] = 1'($urandom_range(0, 1));
        mt.cdb_preg[c]  = ($urandom_range(0, 1) == 1) ? m_num[$urandom_range(0, 7)]
                                                       : 6'($urandom_range(0, 63));
      end
      for (int r = 0; r < RW; r++) begin
        mt.retire_valid[r]    = 1'($urandom_range(0, 1));
        mt.retire_arch_idx[r] = 5'($urandom_range(0, 7));
        mt.retire_preg[r]     = 6'($urandom_range(0, 63));
      end
      mt.restore_enable = ($urandom_range(0, 15) == 0);
      settle();
      edge_step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
